// File: rtl/cache_control.sv
// Sequencing controller for a 2-way set-associative write-back L1 cache:
// hit service, dirty-victim writeback, line allocate, LRU update and perf counters.
module cache_control #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic                   i_hit0,
    input  logic                   i_hit1,
    input  logic                   i_lru,
    input  logic                   i_dirty0,
    input  logic                   i_dirty1,
    input  logic                   i_pmem_resp,
    input  logic                   i_clr_counters,
    output logic                   o_mem_resp,
    output logic                   o_pmem_read,
    output logic                   o_pmem_write,
    output logic                   o_way_sel,
    output logic                   o_load_data,
    output logic                   o_load_tag,
    output logic                   o_load_valid,
    output logic                   o_load_dirty,
    output logic                   o_load_lru,
    output logic                   o_dirty_in,
    output logic                   o_lru_in,
    output logic                   o_data_in_sel,
    output logic                   o_pmem_addr_sel,
    output logic [COUNT_WIDTH-1:0] o_hit_count,
    output logic [COUNT_WIDTH-1:0] o_miss_count,
    output logic [COUNT_WIDTH-1:0] o_wb_count
);

    typedef enum logic [1:0] {
        ST_IDLE_HIT  = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_refill;
    logic [COUNT_WIDTH-1:0] r_hit_count;
    logic [COUNT_WIDTH-1:0] r_miss_count;
    logic [COUNT_WIDTH-1:0] r_wb_count;

    logic w_req;
    logic w_hit;
    logic w_hit_way;
    logic w_victim_dirty;
    logic w_hit_inc;
    logic w_miss_inc;
    logic w_wb_inc;
    logic w_refill_set;

    logic w_mem_resp, w_pmem_read, w_pmem_write, w_way_sel;
    logic w_load_data, w_load_tag, w_load_valid, w_load_dirty, w_load_lru;
    logic w_dirty_in, w_lru_in, w_data_in_sel, w_pmem_addr_sel;

    assign w_req          = i_mem_read | i_mem_write;
    assign w_hit          = i_hit0 | i_hit1;
    assign w_hit_way      = ~i_hit0;
    assign w_victim_dirty = i_lru ? i_dirty1 : i_dirty0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE_HIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_mem_resp      = 1'b0;
        w_pmem_read     = 1'b0;
        w_pmem_write    = 1'b0;
        w_way_sel       = 1'b0;
        w_load_data     = 1'b0;
        w_load_tag      = 1'b0;
        w_load_valid    = 1'b0;
        w_load_dirty    = 1'b0;
        w_load_lru      = 1'b0;
        w_dirty_in      = 1'b0;
        w_lru_in        = 1'b0;
        w_data_in_sel   = 1'b0;
        w_pmem_addr_sel = 1'b0;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        w_wb_inc        = 1'b0;
        w_refill_set    = 1'b0;
        case (r_state)
            ST_IDLE_HIT: begin
                if (w_req && w_hit) begin
                    w_mem_resp = 1'b1;
                    w_load_lru = 1'b1;
                    w_lru_in   = ~w_hit_way;
                    w_way_sel  = w_hit_way;
                    w_hit_inc  = ~r_refill;
                    if (i_mem_write) begin
                        w_load_data  = 1'b1;
                        w_load_dirty = 1'b1;
                        w_dirty_in   = 1'b1;
                    end
                end else if (w_req) begin
                    w_miss_inc = 1'b1;
                    w_next     = w_victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                w_pmem_write    = 1'b1;
                w_pmem_addr_sel = 1'b1;
                w_way_sel       = i_lru;
                if (i_pmem_resp) begin
                    w_wb_inc = 1'b1;
                    w_next   = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                w_pmem_read = 1'b1;
                w_way_sel   = i_lru;
                if (i_pmem_resp) begin
                    w_load_data   = 1'b1;
                    w_data_in_sel = 1'b1;
                    w_load_tag    = 1'b1;
                    w_load_valid  = 1'b1;
                    w_load_dirty  = 1'b1;
                    w_refill_set  = 1'b1;
                    w_next        = ST_IDLE_HIT;
                end
            end
            default: w_next = ST_IDLE_HIT;
        endcase
    end

    // Marks the first IDLE_HIT cycle after a refill so the retry is not counted as a hit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_refill <= 1'b0;
        end else if (r_state == ST_IDLE_HIT) begin
            r_refill <= 1'b0;
        end else if (w_refill_set) begin
            r_refill <= 1'b1;
        end
    end

    // Saturating counters; clear wins over a simultaneous increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else if (i_clr_counters) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_hit_inc && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + COUNT_WIDTH'(1);
            end
            if (w_miss_inc && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + COUNT_WIDTH'(1);
            end
            if (w_wb_inc && (r_wb_count != '1)) begin
                r_wb_count <= r_wb_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Control outputs are combinational, so reset gates them directly.
    assign o_mem_resp      = w_mem_resp      & i_reset_n;
    assign o_pmem_read     = w_pmem_read     & i_reset_n;
    assign o_pmem_write    = w_pmem_write    & i_reset_n;
    assign o_way_sel       = w_way_sel       & i_reset_n;
    assign o_load_data     = w_load_data     & i_reset_n;
    assign o_load_tag      = w_load_tag      & i_reset_n;
    assign o_load_valid    = w_load_valid    & i_reset_n;
    assign o_load_dirty    = w_load_dirty    & i_reset_n;
    assign o_load_lru      = w_load_lru      & i_reset_n;
    assign o_dirty_in      = w_dirty_in      & i_reset_n;
    assign o_lru_in        = w_lru_in        & i_reset_n;
    assign o_data_in_sel   = w_data_in_sel   & i_reset_n;
    assign o_pmem_addr_sel = w_pmem_addr_sel & i_reset_n;
    assign o_hit_count     = r_hit_count;
    assign o_miss_count    = r_miss_count;
    assign o_wb_count      = r_wb_count;

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed scenarios plus random
// transactions checked cycle-by-cycle against a transaction-timeline model.
module tb_cache_control;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic i_clk = 1'b0;
    logic i_reset_n, i_mem_read, i_mem_write, i_hit0, i_hit1, i_lru;
    logic i_dirty0, i_dirty1, i_pmem_resp, i_clr_counters;
    logic o_mem_resp, o_pmem_read, o_pmem_write, o_way_sel, o_load_data, o_load_tag;
    logic o_load_valid, o_load_dirty, o_load_lru, o_dirty_in, o_lru_in;
    logic o_data_in_sel, o_pmem_addr_sel;
    logic [CW-1:0] o_hit_count, o_miss_count, o_wb_count;

    int  vectors     = 0;
    int  miscompares = 0;
    int  m_hit = 0, m_miss = 0, m_wb = 0;
    bit  g_rnd_clr = 1'b0;

    cache_control #(.COUNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_hit0(i_hit0), .i_hit1(i_hit1), .i_lru(i_lru),
        .i_dirty0(i_dirty0), .i_dirty1(i_dirty1), .i_pmem_resp(i_pmem_resp),
        .i_clr_counters(i_clr_counters), .o_mem_resp(o_mem_resp),
        .o_pmem_read(o_pmem_read), .o_pmem_write(o_pmem_write), .o_way_sel(o_way_sel),
        .o_load_data(o_load_data), .o_load_tag(o_load_tag), .o_load_valid(o_load_valid),
        .o_load_dirty(o_load_dirty), .o_load_lru(o_load_lru), .o_dirty_in(o_dirty_in),
        .o_lru_in(o_lru_in), .o_data_in_sel(o_data_in_sel),
        .o_pmem_addr_sel(o_pmem_addr_sel), .o_hit_count(o_hit_count),
        .o_miss_count(o_miss_count), .o_wb_count(o_wb_count)
    );

    always #5 i_clk = ~i_clk;

    // {mem_resp,pmem_read,pmem_write,way_sel,load_data,load_tag,load_valid,
    //  load_dirty,load_lru,dirty_in,lru_in,data_in_sel,pmem_addr_sel}
    wire [12:0] w_outs = {o_mem_resp, o_pmem_read, o_pmem_write, o_way_sel, o_load_data,
                          o_load_tag, o_load_valid, o_load_dirty, o_load_lru, o_dirty_in,
                          o_lru_in, o_data_in_sel, o_pmem_addr_sel};

    function automatic logic [12:0] e_hit(input bit wr, input bit w);
        return {1'b1, 1'b0, 1'b0, w, wr, 1'b0, 1'b0, wr, 1'b1, wr, ~w, 1'b0, 1'b0};
    endfunction

    function automatic logic [12:0] e_wb(input bit l);
        return {1'b0, 1'b0, 1'b1, l, 8'b0, 1'b1};
    endfunction

    function automatic logic [12:0] e_rd(input bit l, input bit last);
        return {1'b0, 1'b1, 1'b0, l, last, last, last, last, 1'b0, 1'b0, 1'b0, last, 1'b0};
    endfunction

    function automatic bit rc();
        return g_rnd_clr && ($urandom_range(0, 15) == 0);
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [3*CW-1:0] exp_c;
        exp_c = {CW'(m_hit), CW'(m_miss), CW'(m_wb)};
        vectors++;
        assert (w_outs === exp) else begin
            miscompares++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, w_outs, exp);
        end
        vectors++;
        assert ({o_hit_count, o_miss_count, o_wb_count} === exp_c) else begin
            miscompares++;
            $error("FAIL %s counters observed=%h expected=%h", tag,
                   {o_hit_count, o_miss_count, o_wb_count}, exp_c);
        end
    endtask

    // One clock cycle: inputs already applied by caller at posedge+1.
    task automatic cyc(input string tag, input logic [12:0] exp, input bit hi,
                       input bit mi, input bit wi, input bit clr);
        i_clr_counters = clr;
        #2;
        chk(tag, exp);
        @(posedge i_clk);
        if (clr) begin
            m_hit = 0; m_miss = 0; m_wb = 0;
        end else begin
            if (hi) m_hit  = sat(m_hit);
            if (mi) m_miss = sat(m_miss);
            if (wi) m_wb   = sat(m_wb);
        end
        #1;
    endtask

    task automatic idle(input string tag);
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_hit0 = 1'b0; i_hit1 = 1'b0;
        i_pmem_resp = 1'b0;
        cyc(tag, 13'd0, 1'b0, 1'b0, 1'b0, rc());
    endtask

    // A complete CPU transaction; drop_at>0 removes the request from that allocate cycle on.
    task automatic do_txn(input string tag, input bit wr, input bit hit, input bit w,
                          input bit lru, input bit dv, input int wl, input int rl,
                          input int drop_at);
        i_mem_write = wr;
        i_mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        i_lru       = lru;
        i_dirty0    = lru ? 1'($urandom_range(0, 1)) : dv;
        i_dirty1    = lru ? dv : 1'($urandom_range(0, 1));
        i_pmem_resp = 1'b0;
        if (hit) begin
            i_hit0 = ~w; i_hit1 = w;
            cyc({tag, "_hit"}, e_hit(wr, w), 1'b1, 1'b0, 1'b0, rc());
        end else begin
            i_hit0 = 1'b0; i_hit1 = 1'b0;
            cyc({tag, "_miss"}, 13'd0, 1'b0, 1'b1, 1'b0, rc());
            if (dv) begin
                for (int c = 1; c <= wl; c++) begin
                    i_pmem_resp = (c == wl);
                    cyc({tag, "_wb"}, e_wb(lru), 1'b0, 1'b0, (c == wl), rc());
                end
            end
            for (int c = 1; c <= rl; c++) begin
                if (drop_at != 0 && c >= drop_at) begin
                    i_mem_read = 1'b0; i_mem_write = 1'b0;
                end
                i_pmem_resp = (c == rl);
                cyc({tag, "_alloc"}, e_rd(lru, c == rl), 1'b0, 1'b0, 1'b0, rc());
            end
            i_pmem_resp = 1'b0;
            if (drop_at == 0) begin
                i_hit0 = ~lru; i_hit1 = lru;
                cyc({tag, "_retry"}, e_hit(wr, lru), 1'b0, 1'b0, 1'b0, rc());
            end
        end
        idle({tag, "_idle"});
    endtask

    initial begin
        i_reset_n = 1'b0; i_mem_read = 1'b1; i_mem_write = 1'b0; i_hit0 = 1'b1;
        i_hit1 = 1'b0; i_lru = 1'b0; i_dirty0 = 1'b0; i_dirty1 = 1'b0;
        i_pmem_resp = 1'b0; i_clr_counters = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #2;
        chk("reset", 13'd0);
        #1 i_reset_n = 1'b1;
        cyc("rst_release", e_hit(1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
        idle("rst_hitcnt");

        do_txn("wr_hit_w1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0);
        do_txn("clean_miss", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 0);
        do_txn("dirty_miss", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2, 0);
        do_txn("drop_alloc", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 4, 2);

        for (int k = 0; k < 20; k++) begin
            do_txn("sat_hits", 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1, 1, 0);
        end
        i_mem_read = 1'b1; i_hit0 = 1'b1; i_hit1 = 1'b0;
        cyc("clr_with_hit", e_hit(1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b1);
        idle("after_clr");

        // Reset asserted mid-allocate abandons the transaction immediately.
        i_mem_read = 1'b1; i_mem_write = 1'b0; i_hit0 = 1'b0; i_hit1 = 1'b0;
        i_lru = 1'b0; i_dirty0 = 1'b0;
        cyc("mid_miss", 13'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mid_alloc", e_rd(1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        #2 i_reset_n = 1'b0;
        #1;
        m_hit = 0; m_miss = 0; m_wb = 0;
        chk("mid_reset", 13'd0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        idle("post_reset");

        g_rnd_clr = 1'b1;
        for (int k = 0; k < 200; k++) begin
            bit hit_r;
            int rl_r;
            hit_r = ($urandom_range(0, 2) != 0);
            rl_r  = $urandom_range(1, 4);
            do_txn("rand", 1'($urandom_range(0, 1)), hit_r, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 4), rl_r,
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, rl_r) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
